// File: rtl/hmac_sha256_iter.sv
// Iterating HMAC-SHA256 engine (PBKDF2 F-function) driving an external SHA-256 compression core.
// Optional ipad/opad midstate reuse across requests when HMAC_KEY_CACHE_EN is defined.
module hmac_sha256_iter #(
  parameter int unsigned KEY_BYTES     = 55,
  parameter int unsigned MAX_MSG_BYTES = 55,
  parameter int unsigned ITER_W        = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [8*KEY_BYTES-1:0]               key_i,
  input  logic [8*MAX_MSG_BYTES-1:0]           msg_i,
  input  logic [$clog2(MAX_MSG_BYTES+1)-1:0]   msg_len_i,
  input  logic [ITER_W-1:0]                    iter_i,
  input  logic                                 v_i,
  output logic                                 r_o,
  output logic [255:0]                         prf_o,
  output logic                                 v_o,
  input  logic                                 r_i,
  output logic                                 cmp_v_o,
  input  logic                                 cmp_r_i,
  output logic [255:0]                         cmp_state_o,
  output logic [511:0]                         cmp_block_o,
  input  logic                                 cmp_v_i,
  input  logic [255:0]                         cmp_digest_i
);

  localparam int unsigned KEY_W = 8 * KEY_BYTES;
  localparam int unsigned MSG_W = 8 * MAX_MSG_BYTES;
  localparam int unsigned LEN_W = $clog2(MAX_MSG_BYTES + 1);
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  typedef enum logic [2:0] {
    S_IDLE, S_IPAD, S_OPAD, S_INNER, S_OUTER, S_WAIT, S_DONE
  } state_t;

  state_t state, state_d, phase, phase_d;

  logic [KEY_W-1:0]  key_q;
  logic [MSG_W-1:0]  msg_q;
  logic [LEN_W-1:0]  len_q;
  logic [ITER_W-1:0] iter_q, j_q;
  logic [255:0]      si_q, so_q, h_q, acc_q;

  logic              r_d, v_d, cmp_v_d;
  logic [255:0]      prf_d, cmp_state_d, acc_next;
  logic [511:0]      cmp_block_d, key_blk, msg_blk, dig_blk;
  logic [LEN_W-1:0]  len_sat;
  logic              accept, hit, first, more;

  // Message block: bytes past the length zeroed, 0x80 marker, bit length of ipad block + message.
  function automatic logic [511:0] pad_msg(input logic [MSG_W-1:0] m, input logic [LEN_W-1:0] n);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < int'(MAX_MSG_BYTES); i++)
      if (LEN_W'(i) < n) b[511-8*i -: 8] = m[MSG_W-1-8*i -: 8];
    for (int i = 0; i <= int'(MAX_MSG_BYTES); i++)
      if (LEN_W'(i) == n) b[511-8*i -: 8] = 8'h80;
    b[63:0] = (64'(n) + 64'd64) << 3;
    return b;
  endfunction

  assign accept   = v_i && r_o;
  assign len_sat  = (msg_len_i > LEN_W'(MAX_MSG_BYTES)) ? LEN_W'(MAX_MSG_BYTES) : msg_len_i;
  assign first    = (j_q == ITER_W'(1));
  assign more     = (j_q < iter_q);
  assign acc_next = first ? cmp_digest_i : (acc_q ^ cmp_digest_i);
  assign msg_blk  = pad_msg(msg_q, len_q);
  assign dig_blk  = {h_q, 8'h80, 184'd0, 64'd768};

  always_comb begin : key_block
    key_blk = '0;
    key_blk[511 -: KEY_W] = key_q;
  end

`ifdef HMAC_KEY_CACHE_EN
  logic key_vld;
  assign hit = key_vld && (key_i == key_q);
`else
  assign hit = 1'b0;
`endif

  // Next-state and registered-output values.
  always_comb begin : fsm_comb
    state_d     = state;
    phase_d     = phase;
    prf_d       = prf_o;
    cmp_v_d     = cmp_v_o;
    cmp_state_d = cmp_state_o;
    cmp_block_d = cmp_block_o;
    case (state)
      S_IDLE: if (accept) state_d = hit ? S_INNER : S_IPAD;
      S_IPAD: begin
        cmp_v_d     = 1'b1;
        cmp_state_d = IV;
        cmp_block_d = key_blk ^ {64{8'h36}};
        phase_d     = S_IPAD;
        state_d     = S_WAIT;
      end
      S_OPAD: begin
        cmp_v_d     = 1'b1;
        cmp_state_d = IV;
        cmp_block_d = key_blk ^ {64{8'h5c}};
        phase_d     = S_OPAD;
        state_d     = S_WAIT;
      end
      S_INNER: begin
        cmp_v_d     = 1'b1;
        cmp_state_d = si_q;
        cmp_block_d = first ? msg_blk : dig_blk;
        phase_d     = S_INNER;
        state_d     = S_WAIT;
      end
      S_OUTER: begin
        cmp_v_d     = 1'b1;
        cmp_state_d = so_q;
        cmp_block_d = dig_blk;
        phase_d     = S_OUTER;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (cmp_r_i) cmp_v_d = 1'b0;
        if (cmp_v_i) begin
          case (phase)
            S_IPAD:  state_d = S_OPAD;
            S_OPAD:  state_d = S_INNER;
            S_INNER: state_d = S_OUTER;
            S_OUTER: begin
              if (more) state_d = S_INNER;
              else begin
                state_d = S_DONE;
                prf_d   = acc_next;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_DONE:  if (r_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    r_d = (state_d == S_IDLE);
    v_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : fsm_reg
    if (rst_i) begin
      state       <= S_IDLE;
      phase       <= S_IDLE;
      r_o         <= 1'b0;
      v_o         <= 1'b0;
      prf_o       <= '0;
      cmp_v_o     <= 1'b0;
      cmp_state_o <= '0;
      cmp_block_o <= '0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      r_o         <= r_d;
      v_o         <= v_d;
      prf_o       <= prf_d;
      cmp_v_o     <= cmp_v_d;
      cmp_state_o <= cmp_state_d;
      cmp_block_o <= cmp_block_d;
    end
  end

  // Request capture and digest bookkeeping; h holds the latest inner or outer digest.
  always_ff @(posedge clk_i or posedge rst_i) begin : datapath
    if (rst_i) begin
      key_q  <= '0;
      msg_q  <= '0;
      len_q  <= '0;
      iter_q <= '0;
      j_q    <= '0;
      si_q   <= '0;
      so_q   <= '0;
      h_q    <= '0;
      acc_q  <= '0;
`ifdef HMAC_KEY_CACHE_EN
      key_vld <= 1'b0;
`endif
    end else begin
      if (accept) begin
        key_q  <= key_i;
        msg_q  <= msg_i;
        len_q  <= len_sat;
        iter_q <= (iter_i == '0) ? ITER_W'(1) : iter_i;
        j_q    <= ITER_W'(1);
      end
      if (state == S_WAIT && cmp_v_i) begin
        case (phase)
          S_IPAD:  si_q <= cmp_digest_i;
          S_OPAD: begin
            so_q <= cmp_digest_i;
`ifdef HMAC_KEY_CACHE_EN
            key_vld <= 1'b1;
`else
            key_q <= '0;
`endif
          end
          S_INNER: h_q <= cmp_digest_i;
          S_OUTER: begin
            h_q   <= cmp_digest_i;
            acc_q <= acc_next;
            if (more) j_q <= j_q + ITER_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hmac_sha256_iter.sv
// Bench for hmac_sha256_iter: behavioural SHA-256 core model plus a byte-level HMAC/PBKDF2 reference.
// Expected compression counts follow HMAC_KEY_CACHE_EN when it is defined for the build.
module tb_hmac_sha256_iter;

  localparam int KB = 55;
  localparam int MB = 55;
  localparam int IW = 16;
  localparam int KW = 8 * KB;
  localparam int MW = 8 * MB;
  localparam int LW = $clog2(MB + 1);
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] RFC2 =
    256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;
  localparam logic [255:0] PB1 =
    256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [255:0] PB2 =
    256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef logic [7:0] bq_t [$];

  logic            clk = 1'b0, rst = 1'b1;
  logic [KW-1:0]   key_i = '0;
  logic [MW-1:0]   msg_i = '0;
  logic [LW-1:0]   msg_len_i = '0;
  logic [IW-1:0]   iter_i = '0;
  logic            v_i = 1'b0, r_i = 1'b0;
  logic            r_o, v_o, cmp_v_o;
  logic [255:0]    prf_o, cmp_state_o;
  logic [511:0]    cmp_block_o;
  logic            cmp_r_i, cmp_v_i;
  logic [255:0]    cmp_digest_i;

  int n_chk = 0, n_err = 0;
  int cmp_cnt = 0, stall_len = 0;
  bit stray_req = 0, cache_ok = 0;
  logic [KW-1:0] cache_key = '0;

  hmac_sha256_iter #(.KEY_BYTES(KB), .MAX_MSG_BYTES(MB), .ITER_W(IW)) dut (
    .clk_i(clk), .rst_i(rst), .key_i(key_i), .msg_i(msg_i), .msg_len_i(msg_len_i),
    .iter_i(iter_i), .v_i(v_i), .r_o(r_o), .prf_o(prf_o), .v_o(v_o), .r_i(r_i),
    .cmp_v_o(cmp_v_o), .cmp_r_i(cmp_r_i), .cmp_state_o(cmp_state_o),
    .cmp_block_o(cmp_block_o), .cmp_v_i(cmp_v_i), .cmp_digest_i(cmp_digest_i));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + st[255:224], b + st[223:192], c + st[191:160], d + st[159:128],
            e + st[127:96],  f + st[95:64],   g + st[63:32],   h + st[31:0]};
  endfunction

  // Full SHA-256 over an arbitrary byte string.
  function automatic logic [255:0] sha256(input bq_t m);
    bq_t p;
    logic [63:0] bits;
    logic [255:0] hs;
    logic [511:0] blk;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    hs = IV;
    for (int o = 0; o < int'(p.size()); o += 64) begin
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[o+i];
      hs = sha_compress(hs, blk);
    end
    return hs;
  endfunction

  function automatic logic [255:0] hmac(input bq_t key, input bq_t msg);
    bq_t ip, op;
    logic [7:0] kb;
    logic [255:0] d;
    for (int i = 0; i < 64; i++) begin
      kb = (i < int'(key.size())) ? key[i] : 8'h00;
      ip.push_back(kb ^ 8'h36);
      op.push_back(kb ^ 8'h5c);
    end
    foreach (msg[i]) ip.push_back(msg[i]);
    d = sha256(ip);
    for (int i = 0; i < 32; i++) op.push_back(d[255-8*i -: 8]);
    return sha256(op);
  endfunction

  // PBKDF2 F: XOR of the chained HMAC outputs.
  function automatic logic [255:0] prf_model(input logic [KW-1:0] key, input logic [MW-1:0] msg,
                                             input int len, input int n);
    bq_t k, m, u;
    logic [255:0] d, t;
    if (len > MB) len = MB;
    if (n == 0) n = 1;
    for (int i = 0; i < KB; i++) k.push_back(key[KW-1-8*i -: 8]);
    for (int i = 0; i < len; i++) m.push_back(msg[MW-1-8*i -: 8]);
    d = hmac(k, m);
    t = d;
    for (int j = 2; j <= n; j++) begin
      u.delete();
      for (int i = 0; i < 32; i++) u.push_back(d[255-8*i -: 8]);
      d = hmac(k, u);
      t ^= d;
    end
    return t;
  endfunction

  function automatic logic [KW-1:0] str_key(input string s);
    logic [KW-1:0] v = '0;
    for (int i = 0; i < s.len(); i++) v[KW-1-8*i -: 8] = s[i];
    return v;
  endfunction

  function automatic logic [MW-1:0] str_msg(input string s);
    logic [MW-1:0] v = '0;
    for (int i = 0; i < s.len(); i++) v[MW-1-8*i -: 8] = s[i];
    return v;
  endfunction

  function automatic bit cache_hit(input logic [KW-1:0] key);
`ifdef HMAC_KEY_CACHE_EN
    return cache_ok && (key == cache_key);
`else
    return (key != key) && cache_ok;
`endif
  endfunction

  // Compression core model: stall, one outstanding job, random latency, one-cycle digest pulse.
  initial begin : core_model
    logic pv, pr, busy;
    logic [255:0] ps, cs;
    logic [511:0] pb, cb;
    int lat, wcnt;
    cmp_r_i = 1'b0; cmp_v_i = 1'b0; cmp_digest_i = '0;
    pv = 0; pr = 0; busy = 0; lat = 0; wcnt = 0; ps = '0; pb = '0; cs = '0; cb = '0;
    forever begin
      @(negedge clk);
      cmp_v_i = 1'b0;
      if (rst) begin
        busy = 0; pv = 0; pr = 0; wcnt = 0; cmp_r_i = 1'b0;
        continue;
      end
      if (pv && pr) begin
        chk("cmp_one_outstanding", 512'(busy), 512'(0));
        busy = 1; cs = ps; cb = pb; lat = $urandom_range(1, 3); cmp_cnt++; wcnt = 0;
      end else if (pv) begin
        chk("cmp_hold_v", 512'(cmp_v_o), 512'(1));
        chk("cmp_hold_state", 512'(cmp_state_o), 512'(ps));
        chk("cmp_hold_block", cmp_block_o, pb);
      end
      if (busy) begin
        lat--;
        if (lat == 0) begin
          cmp_v_i = 1'b1; cmp_digest_i = sha_compress(cs, cb); busy = 0;
        end
      end else if (stray_req) begin
        cmp_v_i = 1'b1; cmp_digest_i = {8{32'hdeadbeef}}; stray_req = 0;
      end
      cmp_r_i = (wcnt >= stall_len);
      if (cmp_v_o) wcnt++;
      pv = cmp_v_o; pr = cmp_r_i; ps = cmp_state_o; pb = cmp_block_o;
    end
  end

  task automatic run(input string tag, input logic [KW-1:0] key, input logic [MW-1:0] msg,
                     input logic [LW-1:0] len, input logic [IW-1:0] it, input int stall,
                     input int hold, input bit noisy, input logic [255:0] exp);
    int n, exp_cmp, c0, cyc;
    n = (it == '0) ? 1 : int'(it);
    exp_cmp = cache_hit(key) ? 2 * n : 2 + 2 * n;
    stall_len = stall;
    cyc = 0;
    while (!r_o && cyc < 50) begin @(negedge clk); cyc++; end
    chk({tag, "_ready"}, 512'(r_o), 512'(1));
    c0 = cmp_cnt;
    key_i = key; msg_i = msg; msg_len_i = len; iter_i = it; v_i = 1'b1;
    @(negedge clk);
    if (noisy) begin
      key_i = ~key; msg_i = ~msg; msg_len_i = ~len; iter_i = it + IW'(5);
    end else v_i = 1'b0;
    cyc = 0;
    while (!v_o && cyc < 4000) begin
      if (noisy) begin
        chk({tag, "_busy_r"}, 512'(r_o), 512'(0));
        r_i = 1'($urandom);
      end
      @(negedge clk); cyc++;
    end
    chk({tag, "_done"}, 512'(v_o), 512'(1));
    v_i = 1'b0; r_i = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold"}, 512'({v_o, r_o, prf_o}), 512'({2'b10, exp}));
      @(negedge clk);
    end
    chk({tag, "_prf"}, 512'(prf_o), 512'(exp));
    chk({tag, "_ncmp"}, 512'(cmp_cnt - c0), 512'(exp_cmp));
    r_i = 1'b1;
    @(negedge clk);
    r_i = 1'b0;
    chk({tag, "_ack"}, 512'({v_o, r_o}), 512'(2'b01));
    cache_ok = 1; cache_key = key;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no completion, required finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [KW-1:0] k, pw_key;
    logic [MW-1:0] m, salt;
    logic [LW-1:0] l;
    logic [IW-1:0] it;
    int klen, pre, cyc, c0;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", 512'({r_o, v_o, cmp_v_o}), 512'(0));
    chk("rst_prf", 512'(prf_o), 512'(0));
    rst = 1'b0;
    chk("rel_r_low", 512'(r_o), 512'(0));
    @(negedge clk);
    chk("rel_r_high", 512'(r_o), 512'(1));

    stray_req = 1;
    repeat (4) @(negedge clk);
    chk("stray_ignored", 512'({r_o, v_o, cmp_v_o}), 512'(3'b100));

    run("rfc2", str_key("Jefe"), str_msg("what do ya want for nothing?"), LW'(28), IW'(1), 0, 0, 0, RFC2);

    pw_key = str_key("password");
    salt = str_msg("salt");
    salt[MW-1-8*7 -: 8] = 8'h01;
    run("pbkdf2_n1", pw_key, salt, LW'(8), IW'(1), 0, 0, 0, PB1);
    run("pbkdf2_n2", pw_key, salt, LW'(8), IW'(2), 0, 0, 0, PB2);

    run("bp", str_key("Jefe"), str_msg("what do ya want for nothing?"), LW'(28), IW'(1), 5, 10, 1, RFC2);

    for (int i = 0; i < MB; i++) m[MW-1-8*i -: 8] = 8'($urandom);
    for (int i = 0; i < KB; i++) k[KW-1-8*i -: 8] = 8'($urandom);
    run("edge", k, m, LW'(63), IW'(0), 1, 2, 0, prf_model(k, m, MB, 1));

    for (int t = 0; t < 8; t++) begin
      if (t == 0 || $urandom_range(0, 1) == 0) begin
        klen = $urandom_range(1, KB);
        for (int i = 0; i < KB; i++) k[KW-1-8*i -: 8] = (i < klen) ? 8'($urandom) : 8'h00;
      end
      for (int i = 0; i < MB; i++) m[MW-1-8*i -: 8] = 8'($urandom);
      l = LW'($urandom_range(0, 63));
      it = IW'($urandom_range(0, 4));
      run("rand", k, m, l, it, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
          prf_model(k, m, int'(l), int'(it)));
    end

    // Abort during the outer compression of the first iteration.
    k = str_key("Jefe");
    m = str_msg("what do ya want for nothing?");
    pre = cache_hit(k) ? 1 : 3;
    stall_len = 5;
    c0 = cmp_cnt;
    key_i = k; msg_i = m; msg_len_i = LW'(28); iter_i = IW'(1); v_i = 1'b1;
    @(negedge clk);
    v_i = 1'b0;
    cyc = 0;
    while (!(cmp_cnt == c0 + pre && cmp_v_o) && cyc < 400) begin @(negedge clk); cyc++; end
    chk("mid_outer_reached", 512'(cmp_v_o), 512'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cmp_v", 512'(cmp_v_o), 512'(0));
    chk("mid_rst_v", 512'(v_o), 512'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cache_ok = 0;
    chk("mid_rel_r_low", 512'(r_o), 512'(0));
    @(negedge clk);
    chk("mid_rel_r_high", 512'(r_o), 512'(1));
    run("post_rst", k, m, LW'(28), IW'(1), 0, 0, 0, RFC2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hmac_sha256_iter.md
Name: hmac_sha256_iter

Overview:
- Parametrised, iterating HMAC-SHA256 engine and successor to the single-shot HMAC block.
- Computes U1 = HMAC(K, M), then Uj = HMAC(K, Uj-1) for j = 2..N, and returns T = U1 ^ U2 ^ ... ^ UN. This is the PBKDF2 F-function for one 256-bit output block.
- Drives an external SHA-256 compression core through a valid/ready request port and a valid-pulse response port.
- Caches the ipad/opad midstates so later iterations cost 2 compressions each.

Parameters:
- KEY_BYTES, 55: width of key_i in bytes. Must be 1..64. The key is left-aligned and zero-extended to a 64-byte pad block.
- MAX_MSG_BYTES, 55: width of msg_i in bytes. Must be 1..55, so that message, 0x80 byte and 64-bit length fit one block.
- ITER_W, 16: width of the iteration count.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- key_i  in  8*KEY_BYTES  key, left-aligned
- msg_i  in  8*MAX_MSG_BYTES  first-iteration message, left-aligned
- msg_len_i  in  $clog2(MAX_MSG_BYTES+1)  message length in bytes
- iter_i  in  ITER_W  iteration count N
- v_i  in  1  request valid
- r_o  out  1  request ready
- prf_o  out  256  result T
- v_o  out  1  result valid
- r_i  in  1  result accepted
- cmp_v_o  out  1  compression request valid
- cmp_r_i  in  1  compression core ready
- cmp_state_o  out  256  chaining state into the core
- cmp_block_o  out  512  message block into the core
- cmp_v_i  in  1  digest valid (1-cycle pulse)
- cmp_digest_i  in  256  chaining state after feed-forward

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; r_o=0 in the reset cycle, then 1; v_o=0, cmp_v_o=0, prf_o=0.
  - All internal registers cleared; key cache invalid.
  - Reset mid-operation aborts the operation, and cmp_v_o drops immediately. The compression core shares rst_i.
- Input handshake:
  - r_o=1 only in IDLE. A request is accepted on v_i & r_o, and key_i, msg_i, msg_len_i, iter_i are registered that cycle.
  - msg_len_i > MAX_MSG_BYTES saturates to MAX_MSG_BYTES.
  - iter_i = 0 is treated as 1.
- Compression handshake:
  - cmp_v_o, cmp_state_o and cmp_block_o are held stable until cmp_r_i, then cmp_v_o drops.
  - The FSM waits for cmp_v_i. Digests arriving in any state other than the wait state are ignored.
  - At most one compression is outstanding.
- FSM:
  - IDLE -> IPAD on accept.
  - IPAD: compress (IV, K^0x36..). Midstate saved to si. -> OPAD.
  - OPAD: compress (IV, K^0x5c..). Midstate saved to so. -> INNER.
  - INNER: compress (si, pad(X, L)).
    - X = msg, L = (64+msg_len)*8 on iteration 1.
    - X = U, L = 768 otherwise.
    - Result saved to h. -> OUTER.
  - OUTER: compress (so, pad(h, 768)).
    - Result is U; acc <= (j==1) ? U : acc^U; j++.
    - -> INNER if j < N, else DONE.
  - DONE: v_o=1, prf_o=acc, held stable until r_i. -> IDLE on r_i.
- pad(X, L):
  - X bytes, then 0x80, then zero fill, then L as big-endian 64 bits in bits [63:0].
  - Message bytes beyond the length are forced to zero.
- Compressions per request: 2 + 2N.
- Iteration counter is ITER_W bits. N = 2^ITER_W - 1 completes without wrap.
- v_i while busy is ignored and not queued.
- r_i while v_o=0 has no effect.

Optional Feature:
- Macro: HMAC_KEY_CACHE_EN.
- Defined:
  - After IPAD/OPAD, the registered key and the validity flag are retained.
  - On a new request whose key equals the cached key with the cache valid, IDLE goes directly to INNER, skipping IPAD/OPAD. This gives 2N compressions.
  - The cache is invalidated only by reset.
- Undefined:
  - Always 2 + 2N compressions.
  - No key storage beyond the current request.

Test Plan:
- RFC 4231 case 2:
  - Stimulus: key "Jefe", msg "what do ya want for nothing?" (28), N=1.
  - Response: prf_o = 5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843; exactly 4 compressions.
- PBKDF2, N=1:
  - Stimulus: key "password", msg "salt"||00000001 (8), N=1.
  - Response: 120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b.
- PBKDF2, N=2:
  - Stimulus: same key and msg, N=2.
  - Response: ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43; 6 compressions. With HMAC_KEY_CACHE_EN issued back-to-back after the N=1 case: 4 compressions, same result.
- Backpressure:
  - Stimulus: hold cmp_r_i=0 for 5 cycles per request, and hold r_i=0 for 10 cycles in DONE.
  - Response: cmp outputs stable while waiting; prf_o/v_o stable until r_i; r_o=0 and v_i ignored throughout.
- Edge inputs:
  - Stimulus: iter_i=0, msg_len_i=63.
  - Response: identical to N=1, msg_len=55.
- Mid-operation reset:
  - Stimulus: assert rst_i during OUTER.
  - Response: v_o=0 and cmp_v_o=0 immediately, r_o=1 after release. A fresh RFC 4231 case 2 request then yields the correct digest and 4 compressions (cache invalid).
